noise_trigger_ctrl: RTL and testbench

- CPU-facing sound control latch and one-shot sequencer for the shell and explosion noise channels.
- Decodes CPU writes to the sound register and turns rising edges of the trigger bits into timed enable pulses aligned to the 12 kHz tick.
- Drives the existing noise source's sound_enable, shell_en/shell_ls and explo_en/explo_ls inputs.

---
 rtl/noise_trigger_ctrl.sv | 141 ++++++++++++++
 tb/tb_noise_trigger_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/noise_trigger_ctrl.sv
// Sound register latch plus shell/explosion one-shot sequencers; every output is a flop,
// one clk after the write or tick. No backpressure: writes and ticks are always accepted.

module noise_chan #(
  parameter int TICKS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic kill,
  input  logic trig,
  input  logic trig_ls,
  output logic en,
  output logic ls,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, ARM, ACTIVE} state_t;

  localparam logic [7:0] RELOAD = 8'(TICKS - 1);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic       en_q;
  logic       ls_q;
  logic       busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      en_q    <= 1'b0;
      ls_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else if (kill) begin
      // ls deliberately holds its last captured value while sound is off
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else if (trig) begin
      // a trigger wins over a coincident tick; en keeps its level until the reload tick
      state_q <= ARM;
      ls_q    <= trig_ls;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ARM: begin
          if (tick) begin
            state_q <= ACTIVE;
            en_q    <= 1'b1;
            cnt_q   <= RELOAD;
          end
        end
        ACTIVE: begin
          if (tick) begin
            if (cnt_q == 8'd0) begin
              state_q <= IDLE;
              en_q    <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign en   = en_q;
  assign ls   = ls_q;
  assign busy = busy_q;
endmodule

module noise_trigger_ctrl #(
  parameter int SHELL_TICKS = 8,
  parameter int EXPLO_TICKS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_12KHz_en,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_data,
  output logic       sound_enable,
  output logic       motor_en,
  output logic       shell_en,
  output logic       shell_ls,
  output logic       explo_en,
  output logic       explo_ls,
  output logic [1:0] busy
);
  logic [5:0] latch_q;
  logic [5:0] latch_d;
  logic       snd_d;
  logic       shell_trig;
  logic       explo_trig;
  logic       unused_hi;

  assign unused_hi = ^cpu_data[7:6];

  // Triggers are gated by the sound enable being written in the same clk.
  always_comb begin
    latch_d = latch_q;
    if (cpu_wr) latch_d = cpu_data[5:0];
    snd_d      = latch_d[5];
    shell_trig = cpu_wr & cpu_data[3] & ~latch_q[3] & snd_d;
    explo_trig = cpu_wr & cpu_data[1] & ~latch_q[1] & snd_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) latch_q <= 6'd0;
    else       latch_q <= latch_d;
  end

  assign sound_enable = latch_q[5];
  assign motor_en     = latch_q[4];

  noise_chan #(.TICKS(SHELL_TICKS)) u_shell (
    .clk     (clk),
    .reset   (reset),
    .tick    (clk_12KHz_en),
    .kill    (~snd_d),
    .trig    (shell_trig),
    .trig_ls (cpu_data[2]),
    .en      (shell_en),
    .ls      (shell_ls),
    .busy    (busy[0])
  );

  noise_chan #(.TICKS(EXPLO_TICKS)) u_explo (
    .clk     (clk),
    .reset   (reset),
    .tick    (clk_12KHz_en),
    .kill    (~snd_d),
    .trig    (explo_trig),
    .trig_ls (cpu_data[0]),
    .en      (explo_en),
    .ls      (explo_ls),
    .busy    (busy[1])
  );
endmodule

// File: tb/tb_noise_trigger_ctrl.sv
// Bench for noise_trigger_ctrl: vector table, directed corner sequences, random run vs model.

module tb_noise_trigger_ctrl;
  localparam int SH_N = 8;
  localparam int EX_N = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_12KHz_en;
  logic       cpu_wr;
  logic [7:0] cpu_data;
  logic       sound_enable, motor_en, shell_en, shell_ls, explo_en, explo_ls;
  logic [1:0] busy;

  noise_trigger_ctrl #(.SHELL_TICKS(SH_N), .EXPLO_TICKS(EX_N)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_12KHz_en (clk_12KHz_en),
    .cpu_wr       (cpu_wr),
    .cpu_data     (cpu_data),
    .sound_enable (sound_enable),
    .motor_en     (motor_en),
    .shell_en     (shell_en),
    .shell_ls     (shell_ls),
    .explo_en     (explo_en),
    .explo_ls     (explo_ls),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 = shell, 1 = explosion.
  logic [7:0] m_latch;
  logic       m_en[2];
  logic       m_pend[2];
  logic       m_ls[2];
  int         m_left[2];

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       tick;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[9];

  function automatic logic [7:0] dut_vec();
    return {sound_enable, motor_en, shell_en, shell_ls, explo_en, explo_ls, busy[1], busy[0]};
  endfunction

  function automatic logic [7:0] model_vec();
    return {m_latch[5], m_latch[4], m_en[0], m_ls[0], m_en[1], m_ls[1],
            m_pend[1] | m_en[1], m_pend[0] | m_en[0]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_latch = 8'h00;
    for (int c = 0; c < 2; c++) begin
      m_en[c] = 1'b0; m_pend[c] = 1'b0; m_ls[c] = 1'b0; m_left[c] = 0;
    end
  endtask

  // m_left counts tick periods still owed to the current pulse.
  task automatic model_step(input logic wr, input logic [7:0] d, input logic tick);
    logic snd;
    snd = wr ? d[5] : m_latch[5];
    for (int c = 0; c < 2; c++) begin
      int tb, lb, n;
      logic trig;
      tb = (c == 0) ? 3 : 1;
      lb = (c == 0) ? 2 : 0;
      n  = (c == 0) ? SH_N : EX_N;
      trig = wr && snd && d[tb] && !m_latch[tb];
      if (!snd) begin
        m_en[c] = 1'b0; m_pend[c] = 1'b0; m_left[c] = 0;
      end else if (trig) begin
        m_pend[c] = 1'b1;
        m_ls[c]   = d[lb];
      end else if (tick) begin
        if (m_pend[c]) begin
          m_pend[c] = 1'b0; m_en[c] = 1'b1; m_left[c] = n;
        end else if (m_en[c]) begin
          m_left[c]--;
          if (m_left[c] == 0) m_en[c] = 1'b0;
        end
      end
    end
    if (wr) m_latch = d;
  endtask

  task automatic cycle(input logic wr, input logic [7:0] d, input logic tick);
    cpu_wr = wr; cpu_data = d; clk_12KHz_en = tick;
    @(posedge clk);
    model_step(wr, d, tick);
    #1;
    check("model", dut_vec(), model_vec());
    cpu_wr = 1'b0; clk_12KHz_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; cpu_wr = 1'b0; cpu_data = 8'h00; clk_12KHz_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("reset_state", dut_vec(), 8'h00);
  endtask

  // Counts ticks that arrive while en is high, until en falls; a low glitch ends it early.
  // Optionally writes wd1 then wd2 once hi reaches wr_at.
  task automatic measure(input int c, input int wr_at, input logic [7:0] wd1,
                         input logic [7:0] wd2, output int hi);
    logic seen, written, t, e;
    hi = 0; seen = 1'b0; written = 1'b0;
    for (int i = 0; i < 600; i++) begin
      t = (i % 3 == 2);
      e = (c == 0) ? shell_en : explo_en;
      if (e) seen = 1'b1;
      if (seen && !e) break;
      if (!written && wr_at >= 0 && hi == wr_at && seen && !t) begin
        cycle(1'b1, wd1, 1'b0);
        cycle(1'b1, wd2, 1'b0);
        written = 1'b1;
      end else begin
        if (t && e) hi++;
        cycle(1'b0, 8'h00, t);
      end
    end
  endtask

  initial begin
    int hi;
    vecs[0] = '{1'b1, 8'h20, 1'b0, 8'h80};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h80};
    vecs[2] = '{1'b1, 8'h38, 1'b0, 8'hC1};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 8'hE1};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 8'hE1};
    vecs[5] = '{1'b1, 8'h10, 1'b0, 8'h40};
    vecs[6] = '{1'b1, 8'h2D, 1'b0, 8'h91};
    vecs[7] = '{1'b1, 8'h2F, 1'b1, 8'hB7};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 8'hBF};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].wr, vecs[i].d, vecs[i].tick);
      check($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
    end

    // Basic shell pulse, soft.
    do_reset();
    cycle(1'b1, 8'h20, 1'b0);
    check("snd_on_busy", {6'b0, busy}, 0);
    cycle(1'b1, 8'h28, 1'b0);
    check("shell_busy_arm", {6'b0, busy}, 1);
    measure(0, -1, 8'h00, 8'h00, hi);
    check("shell_len", hi, SH_N);
    check("shell_ls_soft", shell_ls, 0);
    check("shell_busy_done", {6'b0, busy}, 0);

    // Explosion pulse, loud; rewriting 1 over 1 mid-pulse does not retrigger.
    cycle(1'b1, 8'h23, 1'b0);
    cycle(1'b1, 8'h23, 1'b0);
    measure(1, 10, 8'h23, 8'h23, hi);
    check("explo_len", hi, EX_N);
    check("explo_ls_loud", explo_ls, 1);
    cycle(1'b1, 8'h21, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h23, 1'b0);
    measure(1, -1, 8'h00, 8'h00, hi);
    check("explo_len2", hi, EX_N);

    // Retrigger after 5 high ticks: the reload tick adds one period, then 8 more.
    cycle(1'b1, 8'h28, 1'b0);
    check("shell_ls_pre", shell_ls, 0);
    measure(0, 5, 8'h20, 8'h2C, hi);
    check("shell_retrig_len", hi, 5 + 1 + SH_N);
    check("shell_ls_retrig", shell_ls, 1);

    // Sound off kills an explosion pulse; a write that leaves trig at 1 is no trigger.
    cycle(1'b1, 8'h23, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("explo_on", explo_en, 1);
    cycle(1'b1, 8'h02, 1'b0);
    check("kill_en", explo_en, 0);
    check("kill_busy", {6'b0, busy}, 0);
    check("kill_ls_hold", explo_ls, 1);
    check("kill_snd", sound_enable, 0);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("no_retrig_busy", {6'b0, busy}, 0);
    check("no_retrig_en", explo_en, 0);

    // Asynchronous reset in the middle of a shell pulse.
    cycle(1'b1, 8'h20, 1'b0);
    cycle(1'b1, 8'h28, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check("shell_on_pre_rst", shell_en, 1);
    #2 reset = 1'b1;
    #1 check("async_reset", dut_vec(), 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("post_reset_idle", dut_vec(), 8'h00);
    // latch cleared: writing shell trig with sound on must trigger again
    cycle(1'b1, 8'h28, 1'b0);
    check("post_reset_trig", {6'b0, busy}, 1);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic       wr, tk;
      logic [7:0] d;
      wr = ($urandom_range(0, 7) == 0);
      d  = 8'($urandom);
      d[5] = ($urandom_range(0, 4) != 0);
      tk = ($urandom_range(0, 5) == 0);
      cycle(wr, d, tk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
